seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 181 ++++++++++++++++++
 tb/tb_seg7_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// Reads a two-digit seven-segment display from asynchronous segment lines and
// reports each newly stabilised pattern as a byte, a blank level or an error pulse.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] seg1,
   input  logic [6:0] seg0,
   output logic [7:0] value,
   output logic       valid,
   output logic       error,
   output logic       blank
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Result layout: {in_table, dark, nibble}. A dark digit is not in the table.
   function automatic logic [5:0] decode_digit(input logic [6:0] code);
      logic [5:0] res;
      case (code)
         7'h3F:   res = {2'b10, 4'h0};
         7'h06:   res = {2'b10, 4'h1};
         7'h5B:   res = {2'b10, 4'h2};
         7'h4F:   res = {2'b10, 4'h3};
         7'h66:   res = {2'b10, 4'h4};
         7'h6D:   res = {2'b10, 4'h5};
         7'h7D:   res = {2'b10, 4'h6};
         7'h07:   res = {2'b10, 4'h7};
         7'h7F:   res = {2'b10, 4'h8};
         7'h6F:   res = {2'b10, 4'h9};
         7'h77:   res = {2'b10, 4'hA};
         7'h7C:   res = {2'b10, 4'hB};
         7'h39:   res = {2'b10, 4'hC};
         7'h5E:   res = {2'b10, 4'hD};
         7'h79:   res = {2'b10, 4'hE};
         7'h71:   res = {2'b10, 4'hF};
         7'h00:   res = {2'b01, 4'h0};
         default: res = {2'b00, 4'h0};
      endcase
      return res;
   endfunction

   logic [13:0] sync_a;
   logic [13:0] sync_b;
   logic [13:0] prev_pat;
   logic [13:0] last_pat;
   logic        last_vld;
   logic [7:0]  stable_cnt;
   state_t      state;
   state_t      next_state;

   logic [13:0] norm_pat;
   logic        changed;
   logic        accept;
   logic        hit_last;
   logic [5:0]  dig1;
   logic [5:0]  dig0;
   logic        acc_valid;
   logic        acc_dark;
   logic        acc_err;

   // Two-flop synchronizer on all 14 segment lines
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {seg1, seg0};
         sync_b <= sync_a;
      end
   end

   assign norm_pat = ACTIVE_LOW ? ~sync_b : sync_b;
   assign changed  = (sync_b != prev_pat);
   assign hit_last = last_vld && (sync_b == last_pat);
   assign dig1     = decode_digit(norm_pat[13:7]);
   assign dig0     = decode_digit(norm_pat[6:0]);

   // Stability counter and previous-cycle pattern
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_pat   <= '0;
         stable_cnt <= '0;
      end else begin
         prev_pat <= sync_b;
         if (!enable || changed)
            stable_cnt <= '0;
         else if (stable_cnt != STABLE_MAX)
            stable_cnt <= stable_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Acceptance waits for a steady cycle so a change on the locking edge is not lost
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (enable)
               next_state = TRACK;
         end
         TRACK: begin
            if (stable_cnt == STABLE_MAX && !changed) begin
               next_state = LOCKED;
               accept     = 1'b1;
            end
         end
         LOCKED: begin
            if (changed)
               next_state = TRACK;
         end
         default: next_state = IDLE;
      endcase
      if (!enable) begin
         next_state = IDLE;
         accept     = 1'b0;
      end
   end

   always_comb begin
      acc_valid = 1'b0;
      acc_dark  = 1'b0;
      acc_err   = 1'b0;
      if (accept && !hit_last) begin
         if (dig1[5] && dig0[5])
            acc_valid = 1'b1;
         else if (dig1[4] && dig0[4])
            acc_dark = 1'b1;
         else
            acc_err = 1'b1;
      end
   end

   // Last-accepted marker; cleared while disabled so re-enable re-reports
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_pat <= '0;
         last_vld <= 1'b0;
      end else if (!enable) begin
         last_vld <= 1'b0;
      end else if (accept) begin
         last_pat <= sync_b;
         last_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
         valid <= 1'b0;
         error <= 1'b0;
         blank <= 1'b0;
      end else begin
         valid <= acc_valid;
         error <= acc_err;
         if (acc_valid) begin
            value <= {dig1[3:0], dig0[3:0]};
            blank <= 1'b0;
         end else if (acc_dark) begin
            blank <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (STABLE_CYCLES=4, ACTIVE_LOW=1).
module tb_seg7_reader;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [6:0] seg1;
   logic [6:0] seg0;
   logic [7:0] value;
   logic       valid;
   logic       error;
   logic       blank;

   int checks;
   int errors;

   seg7_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .seg1   (seg1),
      .seg0   (seg0),
      .value  (value),
      .valid  (valid),
      .error  (error),
      .blank  (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset  = 1'b0;
      enable = 1'b1;
      seg1   = ~7'h06;
      seg0   = ~7'h5B;
      #1;
      checks++; if (value !== 8'h00) begin errors++; $display("FAIL reset_value actual=%h required=00", value); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", valid); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error actual=%b required=0", error); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank actual=%b required=0", blank); end
      repeat (2) @(posedge clk);
   endtask

   // Pattern 1,2 is present from reset release; pulse expected 7 edges after the first sample edge.
   task automatic test_first_accept();
      int early;
      early = 0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (i < 7) begin
            if (valid || error) early++;
         end else begin
            checks++; if (early !== 0) begin errors++; $display("FAIL first_early_pulse actual=%0d required=0", early); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid_edge7 actual=%b required=1", valid); end
            checks++; if (value !== 8'h12) begin errors++; $display("FAIL first_value actual=%h required=12", value); end
            checks++; if (blank !== 1'b0) begin errors++; $display("FAIL first_blank actual=%b required=0", blank); end
         end
      end
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_valid_one_cycle actual=%b required=0", valid); end
   endtask

   task automatic test_hold();
      int pulses;
      int both;
      pulses = 0;
      both   = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (valid || error) pulses++;
         if (valid && error) both++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL hold_pulses actual=%0d required=0", pulses); end
      checks++; if (both !== 0) begin errors++; $display("FAIL hold_both actual=%0d required=0", both); end
   endtask

   task automatic test_glitch();
      int pulses;
      pulses = 0;
      @(negedge clk);
      seg0 = ~7'h7F;
      @(posedge clk); #1; if (valid || error) pulses++;
      @(posedge clk); #1; if (valid || error) pulses++;
      @(negedge clk);
      seg0 = ~7'h5B;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid || error) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses actual=%0d required=0", pulses); end
      checks++; if (value !== 8'h12) begin errors++; $display("FAIL glitch_value actual=%h required=12", value); end
   endtask

   task automatic test_invalid();
      int errs;
      int vals;
      int first_err;
      int both;
      errs = 0; vals = 0; first_err = -1; both = 0;
      @(negedge clk);
      seg1 = ~7'h7F;
      seg0 = ~7'h01;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (error) begin errs++; if (first_err < 0) first_err = i; end
         if (valid) vals++;
         if (valid && error) both++;
      end
      checks++; if (errs !== 1) begin errors++; $display("FAIL invalid_error_count actual=%0d required=1", errs); end
      checks++; if (first_err !== 7) begin errors++; $display("FAIL invalid_error_edge actual=%0d required=7", first_err); end
      checks++; if (vals !== 0) begin errors++; $display("FAIL invalid_valid_count actual=%0d required=0", vals); end
      checks++; if (value !== 8'h12) begin errors++; $display("FAIL invalid_value actual=%h required=12", value); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL invalid_blank actual=%b required=0", blank); end
      checks++; if (both !== 0) begin errors++; $display("FAIL invalid_both actual=%0d required=0", both); end
      // One digit dark, the other lit
      errs = 0; vals = 0;
      @(negedge clk);
      seg1 = ~7'h00;
      seg0 = ~7'h06;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (error) errs++;
         if (valid) vals++;
      end
      checks++; if (errs !== 1) begin errors++; $display("FAIL half_dark_error_count actual=%0d required=1", errs); end
      checks++; if (vals !== 0) begin errors++; $display("FAIL half_dark_valid_count actual=%0d required=0", vals); end
      checks++; if (value !== 8'h12) begin errors++; $display("FAIL half_dark_value actual=%h required=12", value); end
   endtask

   task automatic test_dark_then_a5();
      int pulses;
      int vals;
      pulses = 0; vals = 0;
      @(negedge clk);
      seg1 = ~7'h00;
      seg0 = ~7'h00;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid || error) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL dark_pulses actual=%0d required=0", pulses); end
      checks++; if (blank !== 1'b1) begin errors++; $display("FAIL dark_blank actual=%b required=1", blank); end
      checks++; if (value !== 8'h12) begin errors++; $display("FAIL dark_value actual=%h required=12", value); end
      pulses = 0;
      @(negedge clk);
      seg1 = ~7'h77;
      seg0 = ~7'h6D;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid) vals++;
         if (error) pulses++;
      end
      checks++; if (vals !== 1) begin errors++; $display("FAIL a5_valid_count actual=%0d required=1", vals); end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL a5_error_count actual=%0d required=0", pulses); end
      checks++; if (value !== 8'hA5) begin errors++; $display("FAIL a5_value actual=%h required=A5", value); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL a5_blank actual=%b required=0", blank); end
   endtask

   task automatic test_reset_mid();
      int vals;
      int errs;
      vals = 0; errs = 0;
      @(negedge clk);
      seg1 = ~7'h4F;
      seg0 = ~7'h66;
      repeat (4) begin
         @(posedge clk); #1;
         if (valid) vals++;
         if (error) errs++;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (value !== 8'h00) begin errors++; $display("FAIL midreset_value actual=%h required=00", value); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL midreset_blank actual=%b required=0", blank); end
      checks++; if (valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midreset_pulses actual=%b%b required=00", valid, error); end
      @(posedge clk); #1;
      if (valid) vals++;
      if (error) errs++;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (valid) vals++;
         if (error) errs++;
      end
      checks++; if (vals !== 1) begin errors++; $display("FAIL midreset_valid_count actual=%0d required=1", vals); end
      checks++; if (errs !== 0) begin errors++; $display("FAIL midreset_error_count actual=%0d required=0", errs); end
      checks++; if (value !== 8'h34) begin errors++; $display("FAIL midreset_value_after actual=%h required=34", value); end
   endtask

   task automatic test_enable_toggle();
      int vals;
      int pulses;
      vals = 0; pulses = 0;
      @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (valid || error) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL disabled_pulses actual=%0d required=0", pulses); end
      checks++; if (value !== 8'h34) begin errors++; $display("FAIL disabled_value actual=%h required=34", value); end
      pulses = 0;
      @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (valid) vals++;
         if (error) pulses++;
      end
      checks++; if (vals !== 1) begin errors++; $display("FAIL reenable_valid_count actual=%0d required=1", vals); end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL reenable_error_count actual=%0d required=0", pulses); end
      checks++; if (value !== 8'h34) begin errors++; $display("FAIL reenable_value actual=%h required=34", value); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_first_accept();
      test_hold();
      test_glitch();
      test_invalid();
      test_dark_then_a5();
      test_reset_mid();
      test_enable_toggle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
